update_value_slew: RTL
======================

Name: update_value_slew

Overview:
- Downstream consumer of the CPU-written 16-bit update-value PIO output.
- Slew-limits the value seen by the signal path: the output ramps toward a new target in bounded steps at a prescaled rate, instead of jumping, so gain and offset changes cannot glitch the datapath.
- Reports progress with busy/done so the CPU side can observe completion via a status PIO.

Parameters:
- WIDTH, 16, width of target and output value (unsigned).
- STEP, 4, maximum magnitude change per tick (1..2^WIDTH-1).
- DIV, 1000, clk cycles per tick (>=1; DIV=1 means a tick every cycle).
- RESET_VAL, 0, value_out after reset (matches the PIO reset value).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- target_in  input  WIDTH  requested value, driven directly by the update-value PIO out_port.
- bypass  input  1  1 = output follows target with no slewing.
- hold  input  1  1 = freeze the ramp (prescaler and value both hold).
- value_out  output  WIDTH  slewed value to the signal path (registered).
- busy  output  1  1 while ramping (registered).
- done  output  1  one-cycle pulse when a ramp reaches its target (registered).

Behaviour:
- Reset (async, active-high):
  - value_out=RESET_VAL, target_q=RESET_VAL, state=IDLE, cnt=0, busy=0, done=0.
  - Reset asserted mid-ramp abandons the ramp immediately.
- target_q:
  - Registers target_in every cycle; the ramp logic uses only target_q.
  - A target_in change at edge N is visible at edge N+1.
- States: IDLE, RAMP. busy = (state==RAMP). done defaults to 0 each cycle.
- bypass=1 (highest priority after reset):
  - value_out<=target_q, state<=IDLE, cnt<=0, no done pulse.
  - This holds even mid-ramp.
- IDLE:
  - If target_q!=value_out, next edge: state<=RAMP, cnt<=0.
  - value_out is unchanged on that edge.
- RAMP with hold=1: nothing changes, busy stays 1.
- RAMP with target_q==value_out (target moved back): state<=IDLE, done<=1, cnt<=0.
- RAMP otherwise:
  - If cnt!=DIV-1: cnt<=cnt+1.
  - If cnt==DIV-1 (tick): cnt<=0. value_out moves toward target_q by min(STEP, |target_q-value_out|).
  - The difference is computed in WIDTH+1 bits, so there is no wrap at 0 or 2^WIDTH-1 and never any overshoot.
  - If the new value equals target_q: state<=IDLE, done<=1 on the same edge.
- Target change mid-ramp:
  - Direction and distance are recomputed at the next tick from the current value_out.
  - The prescaler is not restarted.
- Latency:
  - First step lands 1 (target_q) + 1 (IDLE->RAMP) + DIV edges after target_in changes.
  - Total ramp takes ceil(|delta|/STEP) ticks.

Decomposition:
- Shared package update_value_pkg holds:
  - state enum (IDLE, RAMP);
  - default WIDTH/STEP/DIV constants;
  - a function returning the clamped next value (current, target, step).
- One natural sub-module: update_value_tick_gen.
  - DIV-cycle prescaler with clear and enable, producing the tick strobe.
  - cnt width is $clog2(DIV) (min 1).

Test Plan:
- Up-ramp, DIV=3, STEP=4: target_in 0->10.
  - value_out steps to 4, 8, 10 on successive ticks 3 cycles apart.
  - busy high throughout; done pulses exactly once, same cycle value hits 10; busy low next cycle.
- Down-ramp with clamp, DIV=1, STEP=4, from 10: target 1.
  - value_out goes 6, 2, 1 on consecutive ramp cycles; no underflow; done once.
- Mid-ramp retarget, DIV=2, STEP=4: 0->100, then after value_out=8 set target 2.
  - Next ticks give 4, then 2; done once at 2.
  - Also move target back to the current value_out: IDLE and done on the next edge.
- Bypass and hold, DIV=2, STEP=4.
  - hold=1 mid-ramp for 10 cycles: value_out and busy frozen.
  - bypass=1: value_out equals target_q next edge, busy 0, no done.
- Reset mid-ramp: assert reset asynchronously (between edges) with value_out=40, target 100.
  - value_out=0, busy=0, done=0 immediately.
  - After release with target_in still 100, ramp restarts from 0.
- Edge values, WIDTH=16, STEP=4, DIV=1: 0xFFFC->0xFFFF and 0x0003->0x0000.
  - Reached in exactly one tick each, no wrap.
  - With STEP=0xFFFF, 0->0xFFFF completes in one tick.

Source files
------------

// File: rtl/update_value_pkg.sv
// Shared types and helpers for the update-value slew limiter.
// Holds the ramp state enum, default parameters and the clamped-step function.
package update_value_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_STEP  = 4;
  localparam int unsigned DEF_DIV   = 1000;

  // One extra bit on the difference keeps the step from wrapping or overshooting
  function automatic logic [31:0] clamp_step(
    input logic [31:0] cur,
    input logic [31:0] tgt,
    input logic [31:0] step
  );
    logic [32:0] diff;
    logic [32:0] mag;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      mag  = (diff > {1'b0, step}) ? {1'b0, step} : diff;
      return cur + mag[31:0];
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      mag  = (diff > {1'b0, step}) ? {1'b0, step} : diff;
      return cur - mag[31:0];
    end
  endfunction

endpackage

// File: rtl/update_value_tick_gen.sv
// DIV-cycle prescaler for the slew limiter.
// Clear wins over enable; the tick strobe fires on the last count.
module update_value_tick_gen
  import update_value_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/update_value_slew.sv
// Slew limiter for the CPU-written update value.
// Ramps value_out toward the registered target in bounded steps per tick.
module update_value_slew
  import update_value_pkg::*;
#(
  parameter int unsigned       WIDTH     = DEF_WIDTH,
  parameter int unsigned       STEP      = DEF_STEP,
  parameter int unsigned       DIV       = DEF_DIV,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target_in,
  input  logic             bypass,
  input  logic             hold,
  output logic [WIDTH-1:0] value_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic [WIDTH-1:0] step_val;
  logic             done_q;
  logic             done_d;
  logic             busy_q;
  logic             at_tgt;
  logic             ramping;
  logic             tick;
  logic             tick_en;
  logic             tick_clr;

  assign at_tgt   = (target_q == value_q);
  assign ramping  = (state_q == RAMP);
  assign step_val = WIDTH'(clamp_step(32'(value_q), 32'(target_q), 32'(STEP)));

  // Prescaler only runs while actively ramping; hold freezes it in place
  assign tick_en  = !bypass && ramping && !hold && !at_tgt;
  assign tick_clr = bypass || !ramping || (!hold && at_tgt);

  update_value_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .en    (tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    done_d  = 1'b0;
    if (bypass) begin
      value_d = target_q;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!at_tgt) state_d = RAMP;
        end
        RAMP: begin
          if (hold) begin
            state_d = RAMP;
          end else if (at_tgt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (tick) begin
            value_d = step_val;
            if (step_val == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= RESET_VAL;
      value_q  <= RESET_VAL;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_in;
      value_q  <= value_d;
      done_q   <= done_d;
      busy_q   <= (state_d == RAMP);
    end
  end

  assign value_out = value_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
